hmac_sha256_ctrl: RTL and testbench
===================================

// Module: hmac_sha256_ctrl
// PURPOSE
//  Sequences one SHA-256 core (block/init/next/ready/digest_valid/digest interface)
//  through the four compressions of HMAC-SHA256 over a fixed 256-bit message.
//  Pads and masks the blocks, chains the inner digest into the outer hash, and
//  presents a start/busy/done handshake.
//  Sits between the attestation/signing logic and the SHA core. Selects the
//  signing key or the PUF response as the HMAC key.
// PARAMETERS
//  TIMEOUT_CYCLES  4096  max cycles to wait for one core compression; 0 disables
//  TO_W            13    timeout counter width, >= clog2(TIMEOUT_CYCLES+1)
// PORTS
//  clk               in   1    clock, all logic on rising edge
//  rst               in   1    asynchronous, active-low reset
//  start             in   1    request; accepted only in IDLE
//  abort             in   1    synchronous abort to IDLE, any state
//  key_sel           in   1    0: signing_key, 1: pufout; sampled with start
//  signing_key       in   256  HMAC key option 0
//  pufout            in   256  HMAC key option 1
//  msg               in   256  message, byte 0 = msg[255:248]; sampled with start
//  busy              out  1    high from accepted start until DONE/ERROR exit
//  done              out  1    1-cycle pulse, hmac valid
//  error             out  1    1-cycle pulse on core timeout
//  hmac              out  256  result, held until next accepted start
//  core_block        out  512  block to SHA core
//  core_init         out  1    1-cycle pulse: hash core_block from IV
//  core_next         out  1    1-cycle pulse: chain core_block onto state
//  core_ready        in   1    core idle, may accept init/next
//  core_digest_valid in   1    core digest valid
//  core_digest       in   256  core digest
// BEHAVIOUR
//  Reset (rst=0): state IDLE. busy/done/error/core_init/core_next = 0.
//   core_block, hmac, latched key/msg, inner digest and timeout counter = 0.
//  K0 = {key, 256'h0}. IPAD = {64{8'h36}}. OPAD = {64{8'h5c}}.
//  Block 1 (init): K0^IPAD.
//  Block 2 (next): {msg, 8'h80, 184'h0, 64'h300}.
//  Block 3 (init): K0^OPAD.
//  Block 4 (next): {inner, 8'h80, 184'h0, 64'h300}. inner = digest after block 2.
//  The length field is 0x300 (768 bits) in both chains.
//  FSM: IDLE -> L1 -> W1 -> L2 -> W2 -> L3 -> W3 -> L4 -> W4 -> DONE -> IDLE.
//   Any Wn may exit to ERROR -> IDLE.
//  IDLE: start=1 latches key (per key_sel) and msg, sets busy, goes to L1.
//   start in any other state is ignored.
//  Ln: waits until core_ready=1. Then, in the same cycle, drives core_block and
//   pulses core_init (L1, L3) or core_next (L2, L4), and moves to Wn.
//   core_block is held stable from Ln through Wn.
//  Wn: ignores the first cycle after the launch, because a stale digest_valid
//   may still be high. After that, waits for core_ready=1 & core_digest_valid=1.
//   W2 captures inner. W4 captures hmac.
//  DONE: done=1 for one cycle, busy drops in the same cycle, returns to IDLE.
//  Timeout: counter clears on each launch and increments in Wn.
//   Reaching TIMEOUT_CYCLES goes to ERROR. ERROR pulses error for one cycle,
//   drops busy and leaves hmac unchanged.
//  abort=1: next state IDLE, no done/error pulse, busy=0.
//   An in-flight core op is not cancelled. The next L1 waits for core_ready.
//  abort and start in the same IDLE cycle: abort wins, start is dropped.
//  Asynchronous rst mid-operation: immediate return to reset values.
//  Never asserts core_init and core_next together. At most one launch per Wn exit.
//  Latency with a core of fixed C cycles, ready at start:
//   done = start + 4*(C+2) + 1 cycles.
// TESTING
//  1 key=0, msg=0, key_sel=0, start -> L1 block={64{8'h36}} with core_init.
//    L2 block={256'h0,8'h80,184'h0,64'h300} with core_next.
//    L3 block={64{8'h5c}} with core_init.
//  2 Random signing_key/msg vs SW HMAC-SHA256 model (RFC 4231 style), real
//    sha core -> hmac matches, done pulses once, busy spans the whole op.
//  3 key_sel=1, pufout=256'hA5..A5 -> block 1 = {256'h93..93, 256'h36..36},
//    hmac equals model for the PUF key.
//  4 Stub core never asserts digest_valid, TIMEOUT_CYCLES=16 -> error pulse
//    17 cycles after the L1 launch, busy=0, no done.
//  5 abort in W3 -> IDLE next cycle, no done. Then start with core busy ->
//    L1 holds until core_ready, result correct.
//  6 start while busy, and rst pulled low in W2 -> start ignored. All outputs
//    at reset values immediately, next op correct.

Source files
------------

// File: rtl/hmac_sha256_ctrl.sv
// HMAC-SHA256 sequencer for a single SHA-256 core.
// Computes HMAC(key, msg) for a fixed 32-byte key and 32-byte message using
// four core compressions: (K0^ipad), (msg||pad), (K0^opad), (inner||pad).
// The key is either the signing key or the PUF response, chosen at start.
//
// state   | meaning
// --------+--------------------------------------------------------------
// S_IDLE  | waiting for start; hmac holds the last result
// S_L1    | block K0^ipad presented, launch init once core_ready
// S_W1    | waiting for the digest of block 1
// S_L2    | block {msg, pad} presented, launch next once core_ready
// S_W2    | waiting for the inner digest, captured on exit
// S_L3    | block K0^opad presented, launch init once core_ready
// S_W3    | waiting for the digest of block 3
// S_L4    | block {inner, pad} presented, launch next once core_ready
// S_W4    | waiting for the final digest, captured into hmac
// S_DONE  | done pulse cycle
// S_ERROR | error pulse cycle after a core timeout

module hmac_sha256_ctrl #(
   parameter int unsigned TIMEOUT_CYCLES = 4096,
   parameter int unsigned TO_W           = 13
) (
   input  logic         i_clk,
   input  logic         i_rst_n,
   input  logic         i_start,
   input  logic         i_abort,
   input  logic         i_key_sel,
   input  logic [255:0] i_signing_key,
   input  logic [255:0] i_pufout,
   input  logic [255:0] i_msg,
   output logic         o_busy,
   output logic         o_done,
   output logic         o_error,
   output logic [255:0] o_hmac,
   output logic [511:0] o_core_block,
   output logic         o_core_init,
   output logic         o_core_next,
   input  logic         i_core_ready,
   input  logic         i_core_digest_valid,
   input  logic [255:0] i_core_digest
);

   typedef enum logic [3:0] {
      S_IDLE, S_L1, S_W1, S_L2, S_W2, S_L3, S_W3, S_L4, S_W4, S_DONE, S_ERROR
   } state_t;

   localparam logic [511:0]      IPAD    = {64{8'h36}};
   localparam logic [511:0]      OPAD    = {64{8'h5c}};
   // Both chains hash 64 bytes of padded key plus 32 bytes: 768 bits.
   localparam logic [255:0]      PAD_768 = {8'h80, 184'h0, 64'h300};
   localparam logic [TO_W-1:0]   TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);

   state_t           r_state;
   logic [255:0]     r_key;
   logic [255:0]     r_msg;
   logic [255:0]     r_inner;
   logic [255:0]     r_hmac;
   logic [511:0]     r_core_block;
   logic [TO_W-1:0]  r_to_cnt;
   logic             r_skip;
   logic             r_busy;
   logic             r_done;
   logic             r_error;
   logic             r_core_init;
   logic             r_core_next;

   logic [255:0]     w_key_new;
   state_t           w_wait_state;
   logic             w_launch_init;

   assign w_key_new = i_key_sel ? i_pufout : i_signing_key;

   // Map each launch state to its wait state and launch kind (init or next)
   always_comb begin
      w_wait_state  = S_W1;
      w_launch_init = 1'b1;
      case (r_state)
         S_L2: begin
            w_wait_state  = S_W2;
            w_launch_init = 1'b0;
         end
         S_L3: w_wait_state = S_W3;
         S_L4: begin
            w_wait_state  = S_W4;
            w_launch_init = 1'b0;
         end
         default: ;
      endcase
   end

   // Main sequencer: state, block staging, launches, timeout and results
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_state      <= S_IDLE;
         r_key        <= '0;
         r_msg        <= '0;
         r_inner      <= '0;
         r_hmac       <= '0;
         r_core_block <= '0;
         r_to_cnt     <= '0;
         r_skip       <= 1'b0;
         r_busy       <= 1'b0;
         r_done       <= 1'b0;
         r_error      <= 1'b0;
         r_core_init  <= 1'b0;
         r_core_next  <= 1'b0;
      end else begin
         r_done      <= 1'b0;
         r_error     <= 1'b0;
         r_core_init <= 1'b0;
         r_core_next <= 1'b0;
         if (i_abort) begin
            // An in-flight core op keeps running; the next L1 waits for ready.
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
         end else begin
            case (r_state)
               S_IDLE: begin
                  if (i_start) begin
                     r_key        <= w_key_new;
                     r_msg        <= i_msg;
                     r_busy       <= 1'b1;
                     r_core_block <= {w_key_new, 256'h0} ^ IPAD;
                     r_state      <= S_L1;
                  end
               end
               S_L1, S_L2, S_L3, S_L4: begin
                  if (i_core_ready) begin
                     r_core_init <= w_launch_init;
                     r_core_next <= ~w_launch_init;
                     r_to_cnt    <= '0;
                     r_skip      <= 1'b1;
                     r_state     <= w_wait_state;
                  end
               end
               S_W1, S_W2, S_W3, S_W4: begin
                  // r_skip masks the launch cycle, where a stale digest_valid
                  // from the previous compression can still be visible.
                  if (!r_skip && i_core_ready && i_core_digest_valid) begin
                     case (r_state)
                        S_W1: begin
                           r_core_block <= {r_msg, PAD_768};
                           r_state      <= S_L2;
                        end
                        S_W2: begin
                           r_inner      <= i_core_digest;
                           r_core_block <= {r_key, 256'h0} ^ OPAD;
                           r_state      <= S_L3;
                        end
                        S_W3: begin
                           r_core_block <= {r_inner, PAD_768};
                           r_state      <= S_L4;
                        end
                        default: begin
                           r_hmac  <= i_core_digest;
                           r_done  <= 1'b1;
                           r_busy  <= 1'b0;
                           r_state <= S_DONE;
                        end
                     endcase
                  end else if ((TIMEOUT_CYCLES != 0) && (r_to_cnt == TO_LAST)) begin
                     r_error <= 1'b1;
                     r_busy  <= 1'b0;
                     r_state <= S_ERROR;
                  end else begin
                     r_skip   <= 1'b0;
                     r_to_cnt <= r_to_cnt + TO_W'(1);
                  end
               end
               S_DONE:  r_state <= S_IDLE;
               S_ERROR: r_state <= S_IDLE;
               default: r_state <= S_IDLE;
            endcase
         end
      end
   end

   assign o_busy       = r_busy;
   assign o_done       = r_done;
   assign o_error      = r_error;
   assign o_hmac       = r_hmac;
   assign o_core_block = r_core_block;
   assign o_core_init  = r_core_init;
   assign o_core_next  = r_core_next;

endmodule

// File: tb/tb_hmac_sha256_ctrl.sv
// Bench for hmac_sha256_ctrl: behavioural SHA-256 core with fixed latency,
// byte-level software HMAC-SHA256 reference, table of vectors plus corner
// sequences (timeout, abort, start while busy, async reset).
module tb_hmac_sha256_ctrl;

   typedef logic [7:0] bq_t [$];

   localparam logic [31:0] K [64] = '{
      32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
      32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
      32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
      32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
      32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
      32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
      32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
      32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2};
   localparam logic [255:0] IV = {32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
                                  32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19};

   function automatic logic [31:0] ror(input logic [31:0] x, input int n);
      return (x >> n) | (x << (32 - n));
   endfunction

   function automatic logic [255:0] sha_compress(input logic [255:0] h, input logic [511:0] blk);
      logic [31:0] w [64];
      logic [31:0] a, b, c, d, e, f, g, hh, t1, t2, s0, s1;
      for (int i = 0; i < 16; i++) w[i] = blk[511-32*i -: 32];
      for (int i = 16; i < 64; i++) begin
         s0 = ror(w[i-15], 7) ^ ror(w[i-15], 18) ^ (w[i-15] >> 3);
         s1 = ror(w[i-2], 17) ^ ror(w[i-2], 19) ^ (w[i-2] >> 10);
         w[i] = w[i-16] + s0 + w[i-7] + s1;
      end
      {a, b, c, d, e, f, g, hh} = h;
      for (int i = 0; i < 64; i++) begin
         t1 = hh + (ror(e, 6) ^ ror(e, 11) ^ ror(e, 25)) + ((e & f) ^ (~e & g)) + K[i] + w[i];
         t2 = (ror(a, 2) ^ ror(a, 13) ^ ror(a, 22)) + ((a & b) ^ (a & c) ^ (b & c));
         hh = g; g = f; f = e; e = d + t1; d = c; c = b; b = a; a = t1 + t2;
      end
      return {a + h[255:224], b + h[223:192], c + h[191:160], d + h[159:128],
              e + h[127:96], f + h[95:64], g + h[63:32], hh + h[31:0]};
   endfunction

   // Plain SHA-256 over a byte string (standard padding).
   function automatic logic [255:0] sha256_bytes(input bq_t m);
      bq_t p;
      logic [63:0]  bl;
      logic [255:0] h;
      logic [511:0] blk;
      p  = m;
      bl = 64'(m.size()) * 64'd8;
      p.push_back(8'h80);
      while (p.size() % 64 != 56) p.push_back(8'h00);
      for (int i = 7; i >= 0; i--) p.push_back(bl[8*i +: 8]);
      h = IV;
      for (int bi = 0; bi < p.size() / 64; bi++) begin
         for (int j = 0; j < 64; j++) blk[511-8*j -: 8] = p[64*bi+j];
         h = sha_compress(h, blk);
      end
      return h;
   endfunction

   // HMAC-SHA256 with a 32-byte key and 32-byte message.
   function automatic logic [255:0] hmac_model(input logic [255:0] key, input logic [255:0] msg,
                                               output logic [255:0] inner);
      bq_t a, b;
      logic [7:0] kb;
      for (int i = 0; i < 64; i++) begin
         if (i < 32) kb = key[255-8*i -: 8];
         else        kb = 8'h00;
         a.push_back(kb ^ 8'h36);
         b.push_back(kb ^ 8'h5c);
      end
      for (int i = 0; i < 32; i++) a.push_back(msg[255-8*i -: 8]);
      inner = sha256_bytes(a);
      for (int i = 0; i < 32; i++) b.push_back(inner[255-8*i -: 8]);
      return sha256_bytes(b);
   endfunction

   function automatic logic [255:0] rand256();
      logic [255:0] r;
      r = '0;
      for (int i = 0; i < 8; i++) r = {r[223:0], 32'($urandom())};
      return r;
   endfunction

   typedef struct {
      logic         ks;
      logic [255:0] skey;
      logic [255:0] puf;
      logic [255:0] msg;
      int           lat;
      logic [255:0] exp_hmac;
      logic [255:0] exp_inner;
   } vec_t;

   typedef struct {
      logic         is_init;
      logic [511:0] blk;
   } launch_t;

   logic         clk = 1'b0;
   logic         rst_n, core_rst_n;
   logic         start, abort, key_sel, t_start, t_abort;
   logic [255:0] skey, puf, msg;
   logic         o_busy, o_done, o_error, o_core_init, o_core_next;
   logic [255:0] o_hmac;
   logic [511:0] o_core_block;
   logic         core_ready, core_dv;
   logic [255:0] core_dig, core_h;
   int           core_cnt, core_lat;
   logic         t_busy, t_done, t_error, t_init, t_next;
   logic [255:0] t_hmac;
   logic [511:0] t_block;

   int checks = 0, failures = 0;
   int done_cnt = 0, err_cnt = 0, both_cnt = 0, bad_launch = 0;
   launch_t lq [$];
   vec_t vecs [6];

   always #5 clk = ~clk;

   hmac_sha256_ctrl dut (
      .i_clk(clk), .i_rst_n(rst_n), .i_start(start), .i_abort(abort), .i_key_sel(key_sel),
      .i_signing_key(skey), .i_pufout(puf), .i_msg(msg),
      .o_busy(o_busy), .o_done(o_done), .o_error(o_error), .o_hmac(o_hmac),
      .o_core_block(o_core_block), .o_core_init(o_core_init), .o_core_next(o_core_next),
      .i_core_ready(core_ready), .i_core_digest_valid(core_dv), .i_core_digest(core_dig));

   // Second instance against a core that never completes.
   hmac_sha256_ctrl #(.TIMEOUT_CYCLES(16), .TO_W(5)) dut_to (
      .i_clk(clk), .i_rst_n(rst_n), .i_start(t_start), .i_abort(t_abort), .i_key_sel(key_sel),
      .i_signing_key(skey), .i_pufout(puf), .i_msg(msg),
      .o_busy(t_busy), .o_done(t_done), .o_error(t_error), .o_hmac(t_hmac),
      .o_core_block(t_block), .o_core_init(t_init), .o_core_next(t_next),
      .i_core_ready(1'b1), .i_core_digest_valid(1'b0), .i_core_digest(256'h0));

   // Behavioural SHA core: accepts init/next when ready, busy for core_lat
   // cycles, digest_valid stays high until the next accepted launch.
   always @(posedge clk) begin
      if (!core_rst_n) begin
         core_ready <= 1'b1; core_dv <= 1'b0; core_cnt <= 0; core_dig <= '0; core_h <= IV;
      end else if (core_cnt != 0) begin
         core_cnt <= core_cnt - 1;
         if (core_cnt == 1) begin
            core_ready <= 1'b1; core_dv <= 1'b1; core_dig <= core_h;
         end
      end else if (core_ready && (o_core_init || o_core_next)) begin
         core_h     <= sha_compress(o_core_init ? IV : core_h, o_core_block);
         core_ready <= 1'b0;
         core_dv    <= 1'b0;
         core_cnt   <= core_lat;
      end
   end

   initial forever begin
      @(negedge clk);
      if (o_core_init || o_core_next) lq.push_back('{o_core_init, o_core_block});
      if (o_core_init && o_core_next) both_cnt++;
      if ((o_core_init || o_core_next) && !core_ready) bad_launch++;
      if (o_done) done_cnt++;
      if (o_error) err_cnt++;
   end

   task automatic chk(input string name, input logic [511:0] act, input logic [511:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   task automatic wait_launches(input int n, input string name);
      for (int c = 0; c < 1000 && lq.size() < n; c++) @(negedge clk);
      chk(name, 512'(lq.size() >= n), 512'd1);
   endtask

   task automatic drive_start(input vec_t v);
      @(negedge clk);
      key_sel = v.ks; skey = v.skey; puf = v.puf; msg = v.msg; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic run_op(input vec_t v, input bit poke, input string nm);
      int d0, e0, busy_bad;
      bit got;
      core_lat = v.lat; lq.delete(); d0 = done_cnt; e0 = err_cnt; busy_bad = 0; got = 0;
      drive_start(v);
      for (int c = 0; c < 3000 && !got; c++) begin
         if (o_done) got = 1;
         else begin
            if (!o_busy) busy_bad++;
            if (poke && c == 6) begin
               start = 1'b1; key_sel = ~v.ks; skey = ~v.skey; puf = ~v.puf; msg = ~v.msg;
            end
            if (poke && c == 7) begin
               start = 1'b0; key_sel = v.ks; skey = v.skey; puf = v.puf; msg = v.msg;
            end
            @(negedge clk);
         end
      end
      chk({nm, "_done_seen"}, 512'(got), 512'd1);
      chk({nm, "_hmac"}, 512'(o_hmac), 512'(v.exp_hmac));
      chk({nm, "_busy_at_done"}, 512'(o_busy), 512'd0);
      chk({nm, "_busy_span"}, 512'(busy_bad), 512'd0);
      @(negedge clk);
      chk({nm, "_done_pulse_once"}, 512'(done_cnt - d0), 512'd1);
      chk({nm, "_no_error"}, 512'(err_cnt - e0), 512'd0);
      chk({nm, "_launches"}, 512'(lq.size()), 512'd4);
      if (lq.size() == 4) begin
         chk({nm, "_kinds"}, 512'({lq[0].is_init, lq[1].is_init, lq[2].is_init, lq[3].is_init}), 512'(4'b1010));
         chk({nm, "_block4"}, lq[3].blk, {v.exp_inner, 8'h80, 184'h0, 64'h300});
      end
   endtask

   initial begin
      logic [255:0] kk;
      int ti, te, tdone, terr, d0;
      bit tb_busy;
      rst_n = 1'b0; core_rst_n = 1'b0; start = 1'b0; abort = 1'b0; key_sel = 1'b0;
      t_start = 1'b0; t_abort = 1'b0; skey = '0; puf = '0; msg = '0; core_lat = 3;
      repeat (3) @(negedge clk);
      chk("rst_busy", 512'(o_busy), 512'd0);
      chk("rst_done_error", 512'({o_done, o_error}), 512'd0);
      chk("rst_init_next", 512'({o_core_init, o_core_next}), 512'd0);
      chk("rst_block", o_core_block, 512'd0);
      chk("rst_hmac", 512'(o_hmac), 512'd0);
      rst_n = 1'b1; core_rst_n = 1'b1;

      vecs[0] = '{ks: 1'b0, skey: '0, puf: rand256(), msg: '0, lat: 3, exp_hmac: '0, exp_inner: '0};
      vecs[1] = '{ks: 1'b1, skey: rand256(), puf: {32{8'hA5}}, msg: rand256(), lat: 5, exp_hmac: '0, exp_inner: '0};
      for (int i = 2; i < 6; i++)
         vecs[i] = '{ks: 1'($urandom_range(0, 1)), skey: rand256(), puf: rand256(), msg: rand256(),
                     lat: int'($urandom_range(1, 8)), exp_hmac: '0, exp_inner: '0};
      for (int i = 0; i < 6; i++) begin
         kk = vecs[i].ks ? vecs[i].puf : vecs[i].skey;
         vecs[i].exp_hmac = hmac_model(kk, vecs[i].msg, vecs[i].exp_inner);
      end

      for (int i = 0; i < 6; i++) begin
         run_op(vecs[i], i == 3, $sformatf("v%0d", i));
         if (i == 0 && lq.size() == 4) begin
            chk("v0_block1", lq[0].blk, {64{8'h36}});
            chk("v0_block2", lq[1].blk, {256'h0, 8'h80, 184'h0, 64'h300});
            chk("v0_block3", lq[2].blk, {64{8'h5c}});
         end
         if (i == 1 && lq.size() == 4)
            chk("v1_puf_block1", lq[0].blk, {{32{8'h93}}, {32{8'h36}}});
      end

      // abort and start together in IDLE: abort wins
      lq.delete();
      @(negedge clk); start = 1'b1; abort = 1'b1; key_sel = 1'b0;
      @(negedge clk); start = 1'b0; abort = 1'b0;
      chk("abort_start_busy", 512'(o_busy), 512'd0);
      repeat (4) @(negedge clk);
      chk("abort_start_no_launch", 512'(lq.size()), 512'd0);

      // timeout: core never completes
      @(negedge clk); t_start = 1'b1;
      @(negedge clk); t_start = 1'b0;
      ti = -1; te = -1; tdone = 0; terr = 0; tb_busy = 1'b1;
      for (int c = 0; c < 60; c++) begin
         if (t_init && ti < 0) ti = c;
         if (t_error) begin
            terr++;
            if (te < 0) begin te = c; tb_busy = t_busy; end
         end
         if (t_done) tdone++;
         @(negedge clk);
      end
      chk("to_init_seen", 512'(ti >= 0), 512'd1);
      // init pulse is visible the cycle after the L1 launch decision
      chk("to_error_delay", 512'(te - ti), 512'd16);
      chk("to_busy_at_error", 512'(tb_busy), 512'd0);
      chk("to_error_once", 512'(terr), 512'd1);
      chk("to_no_done", 512'(tdone), 512'd0);
      chk("to_busy_after", 512'(t_busy), 512'd0);

      // abort in W3 with a slow core, then restart while the core is busy
      core_lat = 20; lq.delete(); d0 = done_cnt;
      drive_start(vecs[2]);
      wait_launches(3, "abort_reach_w3");
      @(negedge clk); abort = 1'b1;
      @(negedge clk); abort = 1'b0;
      chk("abort_busy", 512'(o_busy), 512'd0);
      chk("abort_no_pulse", 512'({o_done, o_error, o_core_init, o_core_next}), 512'd0);
      chk("abort_no_done", 512'(done_cnt - d0), 512'd0);
      vecs[4].lat = 20;
      run_op(vecs[4], 1'b0, "after_abort");

      // async reset in W2
      core_lat = 4; lq.delete();
      drive_start(vecs[5]);
      wait_launches(2, "rst_reach_w2");
      @(negedge clk); #2 rst_n = 1'b0;
      #1;
      chk("arst_busy", 512'(o_busy), 512'd0);
      chk("arst_pulses", 512'({o_done, o_error, o_core_init, o_core_next}), 512'd0);
      chk("arst_block", o_core_block, 512'd0);
      chk("arst_hmac", 512'(o_hmac), 512'd0);
      @(negedge clk); rst_n = 1'b1;
      run_op(vecs[1], 1'b0, "after_rst");

      chk("init_next_exclusive", 512'(both_cnt), 512'd0);
      chk("launch_only_when_ready", 512'(bad_launch), 512'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
